alu_ctrl_muldiv: RTL and testbench
==================================

Name: alu_ctrl_muldiv

Overview:
Next-generation ALU controller for the RV32 core's EX stage. It decodes ALUOp/Funct7/Funct3 into the 4-bit ALU Operation code, with complete branch and unsigned-compare coverage. It also adds the RV32M extension as a parametrised iterative multiply/divide engine. While an M-instruction is in EX, the engine stalls the pipeline with a start/stall/valid handshake and delivers the result for the writeback mux.

Parameters:
WIDTH, 32, datapath width in bits (even, >= 8).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
valid_i  in  1  instruction in EX is valid (not a bubble)
flush_i  in  1  EX being flushed (branch/jump); aborts any M operation
ALUOp  in  2  00 LW/SW/AUIPC; 01 branch; 10 R/I-type; 11 JAL/LUI
Funct7  in  7  instruction bits 31:25
Funct3  in  3  instruction bits 14:12
is_rtype  in  1  1 = R-type (Funct7 meaningful); 0 = I-type
SrcA  in  WIDTH  rs1 operand
SrcB  in  WIDTH  rs2 operand
Operation  out  4  ALU operation select (combinational)
muldiv_result  out  WIDTH  M-extension result, registered
muldiv_valid  out  1  one-cycle pulse: muldiv_result valid for the instruction in EX
stall  out  1  hold PC/IF/ID/EX; combinational
busy  out  1  engine in RUN state

Behaviour:
- Operation encoding: 0000 AND; 0001 OR; 0010 XOR; 0011 ADD; 0100 SUB; 0101 SRL; 0110 SRA; 0111 SLL; 1000 GEU; 1001 EQ; 1010 NE; 1011 LT; 1100 GE; 1101 PASS_B (LUI/JAL); 1110 LTU; 1111 MULDIV (ALU output ignored, writeback takes muldiv_result).
- ALUOp 00 -> 0011. ALUOp 11 -> 1101.
- ALUOp 01 (branches), by Funct3: 000->1001, 001->1010, 100->1011, 101->1100, 110->1110, 111->1000; 010/011 -> 1001.
- ALUOp 10, by Funct3:
  - 000: SUB (0100) only if is_rtype && Funct7=0100000; otherwise ADD (0011).
  - 001 -> 0111; 010 -> 1011; 011 -> 1110; 100 -> 0010; 110 -> 0001; 111 -> 0000.
  - 101: Funct7=0100000 -> 0110, else 0101.
  - is_rtype && Funct7=0000001 overrides all of the above -> 1111 (is_md).
- Operation is purely combinational and independent of engine state.
- Engine FSM, states IDLE, RUN, DONE; reset -> IDLE.
  - Reset values: muldiv_result=0, muldiv_valid=0, busy=0, counter=0.
- IDLE: if valid_i && is_md && !flush_i:
  - Latch Funct3 and operands.
  - Special case (div/rem with SrcB=0, or DIV/REM with SrcA=2^(WIDTH-1) and SrcB=all-ones): compute result, go to DONE.
  - Otherwise load counter=WIDTH and go to RUN.
- RUN: one bit per cycle.
  - Multiply: shift-add over magnitudes, 2*WIDTH-bit product.
  - Divide: restoring division over magnitudes.
  - Counter decrements each cycle; at counter=1 the final sign fix-up (two's-complement negate) is applied and the result is registered; go to DONE.
- DONE: muldiv_valid=1 for exactly this cycle; go to IDLE.
- Latency: issue cycle T (IDLE); RUN occupies T+1..T+WIDTH; muldiv_valid at T+WIDTH+1. Special-case ops: muldiv_valid at T+1.
- stall = valid_i && is_md && (state != DONE) && !flush_i. stall is low in the DONE cycle so the pipeline advances exactly once. No re-issue is possible because the FSM leaves DONE.
- Sign rules:
  - MUL: low WIDTH bits of the product.
  - MULH: signed x signed, high half.
  - MULHSU: signed SrcA x unsigned SrcB, high half.
  - MULHU: unsigned x unsigned, high half.
  - DIV/REM signed: quotient sign = sign(A) xor sign(B); remainder sign = sign(A). DIVU/REMU unsigned.
- Division by zero: quotient = all-ones; remainder = SrcA.
- Signed overflow (min / -1): quotient = 2^(WIDTH-1); remainder = 0.
- flush_i in any state: next state IDLE; no muldiv_valid; result register unchanged.
- reset in any state (mid-RUN included): all outputs to reset values next cycle.
- Operands and Funct3 are used only as latched at issue; input changes during RUN are ignored.
- busy=1 only in RUN.

Test Plan:
- Decode sweep: ALUOp=10, Funct3=000, is_rtype=1, Funct7=0100000 -> 0100; is_rtype=0, same Funct7 -> 0011; ALUOp=01, Funct3=111 -> 1000; ALUOp=11 -> 1101; Funct7=0000001 R-type -> 1111.
- MUL 7 x 0xFFFFFFFD (WIDTH=32): stall high for 33 cycles; muldiv_valid pulse at T+33 with result 0xFFFFFFEB; stall low in that cycle.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 5 / 0 -> 0xFFFFFFFF in 2 cycles; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Abort: flush_i asserted at RUN cycle 10 -> IDLE next cycle, no muldiv_valid, stall low. Repeat with reset mid-RUN -> all outputs 0.
- Back-to-back: two consecutive MULs -> second issues the cycle after DONE; each produces exactly one muldiv_valid pulse. Non-M instruction with valid_i=1 -> stall never asserted.

Source files
------------

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU controller: decodes ALUOp/Funct7/Funct3 into the ALU operation code and
// runs an iterative RV32M multiply/divide engine with a stall/valid pipeline handshake.
module alu_ctrl_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             is_rtype,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [3:0]       Operation,
  output logic [WIDTH-1:0] muldiv_result,
  output logic             muldiv_valid,
  output logic             stall,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_SRL, OP_SRA, OP_SLL,
    OP_GEU, OP_EQ, OP_NE, OP_LT, OP_GE, OP_PASSB, OP_LTU, OP_MULDIV
  } alu_op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  alu_op_e op_d;
  logic    is_md;

  always_comb begin
    is_md = (ALUOp == 2'b10) && is_rtype && (Funct7 == 7'b0000001);
    op_d  = OP_ADD;
    case (ALUOp)
      2'b00: op_d = OP_ADD;
      2'b11: op_d = OP_PASSB;
      2'b01: begin
        case (Funct3)
          3'b001:  op_d = OP_NE;
          3'b100:  op_d = OP_LT;
          3'b101:  op_d = OP_GE;
          3'b110:  op_d = OP_LTU;
          3'b111:  op_d = OP_GEU;
          default: op_d = OP_EQ;
        endcase
      end
      default: begin
        case (Funct3)
          3'b000:  op_d = (is_rtype && Funct7 == 7'b0100000) ? OP_SUB : OP_ADD;
          3'b001:  op_d = OP_SLL;
          3'b010:  op_d = OP_LT;
          3'b011:  op_d = OP_LTU;
          3'b100:  op_d = OP_XOR;
          3'b101:  op_d = (Funct7 == 7'b0100000) ? OP_SRA : OP_SRL;
          3'b110:  op_d = OP_OR;
          default: op_d = OP_AND;
        endcase
        if (is_md) op_d = OP_MULDIV;
      end
    endcase
  end

  assign Operation = op_d;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Issue-time operand conditioning: both engines work on magnitudes, sign restored at the end
  logic             sgn_a_en, sgn_b_en, a_neg, b_neg, div_zero, div_ovf, special;
  logic [WIDTH-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    sgn_a_en = Funct3[2] ? !Funct3[0] : (Funct3[1:0] == 2'b01 || Funct3[1:0] == 2'b10);
    sgn_b_en = Funct3[2] ? !Funct3[0] : (Funct3[1:0] == 2'b01);
    a_neg    = sgn_a_en && SrcA[WIDTH-1];
    b_neg    = sgn_b_en && SrcB[WIDTH-1];
    a_mag    = a_neg ? ('0 - SrcA) : SrcA;
    b_mag    = b_neg ? ('0 - SrcB) : SrcB;
    div_zero = (SrcB == '0);
    div_ovf  = !Funct3[0] && (SrcA == MIN_VAL) && (SrcB == '1);
    special  = Funct3[2] && (div_zero || div_ovf);
    if (div_zero) spec_res = Funct3[1] ? SrcA : '1;
    else          spec_res = Funct3[1] ? '0 : MIN_VAL;
  end

  // One iteration of each engine; hi/lo/b registers are shared between multiply and divide
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   mul_hi, mul_lo, div_hi, div_lo, step_hi, step_lo, div_val, div_fix;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic               div_ok;
  logic [WIDTH-1:0]   fin_res;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    mul_hi    = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ok    = !div_diff[WIDTH];
    div_hi    = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo    = {lo_q[WIDTH-2:0], div_ok};
    step_hi   = f3_q[2] ? div_hi : mul_hi;
    step_lo   = f3_q[2] ? div_lo : mul_lo;
    prod      = {mul_hi, mul_lo};
    prod_fix  = neg_q ? ('0 - prod) : prod;
    div_val   = f3_q[1] ? div_hi : div_lo;
    div_fix   = neg_q ? ('0 - div_val) : div_val;
    if (f3_q[2])                fin_res = div_fix;
    else if (f3_q[1:0] == 2'b00) fin_res = prod_fix[WIDTH-1:0];
    else                        fin_res = prod_fix[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i && is_md && !flush_i) begin
          f3_d  = Funct3;
          hi_d  = '0;
          lo_d  = a_mag;
          b_d   = b_mag;
          neg_d = (Funct3[2] && Funct3[1]) ? a_neg : (a_neg ^ b_neg);
          if (special) begin
            result_d = spec_res;
            state_d  = S_DONE;
          end else begin
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          result_d = fin_res;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign muldiv_result = result_q;
  assign muldiv_valid  = (state_q == S_DONE);
  assign busy          = (state_q == S_RUN);
  assign stall         = valid_i && is_md && (state_q != S_DONE) && !flush_i;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Bench for alu_ctrl_muldiv: decode sweep plus RV32M results and handshake timing
// against a 64-bit arithmetic reference model.
module tb_alu_ctrl_muldiv;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, valid_i, flush_i, is_rtype;
  logic [1:0]    ALUOp;
  logic [6:0]    Funct7;
  logic [2:0]    Funct3;
  logic [W-1:0]  SrcA, SrcB;
  logic [3:0]    Operation;
  logic [W-1:0]  muldiv_result;
  logic          muldiv_valid, stall, busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_exp = '0;

  always #5 clk = ~clk;

  alu_ctrl_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .is_rtype(is_rtype),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .muldiv_result(muldiv_result), .muldiv_valid(muldiv_valid),
    .stall(stall), .busy(busy)
  );

  logic [2:0]  mf3  [4] = '{3'd0, 3'd3, 3'd1, 3'd2};
  logic [31:0] ma   [4] = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
  logic [31:0] mb   [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
  logic [31:0] mexp [4] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF};
  logic [2:0]  df3  [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
  logic [31:0] da   [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] db   [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] dexp [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

  function automatic logic [3:0] ref_op(input logic [1:0] aluop, input logic [6:0] f7,
                                        input logic [2:0] f3, input logic rt);
    if (aluop == 2'b00) return 4'd3;
    if (aluop == 2'b11) return 4'd13;
    if (aluop == 2'b01) begin
      case (f3)
        3'd1: return 4'd10;
        3'd4: return 4'd11;
        3'd5: return 4'd12;
        3'd6: return 4'd14;
        3'd7: return 4'd8;
        default: return 4'd9;
      endcase
    end
    if (rt && f7 == 7'b0000001) return 4'd15;
    case (f3)
      3'd0: return (rt && f7 == 7'b0100000) ? 4'd4 : 4'd3;
      3'd1: return 4'd7;
      3'd2: return 4'd11;
      3'd3: return 4'd14;
      3'd4: return 4'd2;
      3'd5: return (f7 == 7'b0100000) ? 4'd6 : 4'd5;
      3'd6: return 4'd1;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    return W + 1;
  endfunction

  task automatic drive_idle();
    valid_i = 1'b0; flush_i = 1'b0; ALUOp = 2'b00; Funct7 = '0; Funct3 = '0;
    is_rtype = 1'b0; SrcA = '0; SrcB = '0;
  endtask

  // Issues one M instruction and observes it until muldiv_valid; operands are scrambled while it runs.
  task automatic do_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output int n_stall,
                       output int n_busy, output logic stall_done);
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b0; ALUOp = 2'b10; is_rtype = 1'b1; Funct7 = 7'b0000001;
    Funct3 = f3; SrcA = a; SrcB = b;
    lat = -1; res = 'x; n_stall = 0; n_busy = 0; stall_done = 1'bx;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) begin
        @(negedge clk);
        SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
      end
      #1;
      if (muldiv_valid) begin
        lat = k; res = muldiv_result; stall_done = stall;
        break;
      end
      n_stall += int'(stall);
      n_busy  += int'(busy);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (muldiv_result !== '0 || muldiv_valid !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got result=%h valid=%b busy=%b stall=%b, expected all zero",
               muldiv_result, muldiv_valid, busy, stall);
    end
    reset = 1'b0;
  endtask

  task automatic test_decode();
    logic [6:0] f7s [4] = '{7'b0100000, 7'b0000001, 7'b0000000, 7'b0000000};
    for (int i = 0; i < 305; i++) begin
      logic [3:0] exp;
      @(negedge clk);
      valid_i = 1'b0;
      case (i)
        0: begin ALUOp = 2'b10; Funct3 = 3'd0; is_rtype = 1'b1; Funct7 = 7'b0100000; end
        1: begin ALUOp = 2'b10; Funct3 = 3'd0; is_rtype = 1'b0; Funct7 = 7'b0100000; end
        2: begin ALUOp = 2'b01; Funct3 = 3'd7; is_rtype = 1'b0; Funct7 = 7'b0000000; end
        3: begin ALUOp = 2'b11; Funct3 = 3'd5; is_rtype = 1'b1; Funct7 = 7'b0100000; end
        4: begin ALUOp = 2'b10; Funct3 = 3'd3; is_rtype = 1'b1; Funct7 = 7'b0000001; end
        default: begin
          ALUOp = 2'($urandom); Funct3 = 3'($urandom); is_rtype = 1'($urandom);
          Funct7 = ($urandom_range(0, 4) == 0) ? 7'($urandom) : f7s[$urandom_range(0, 3)];
        end
      endcase
      exp = ref_op(ALUOp, Funct7, Funct3, is_rtype);
      #1;
      n_checks++;
      if (Operation !== exp) begin
        n_fail++;
        $display("FAIL decode[%0d] ALUOp=%b F7=%b F3=%b rt=%b: got %b expected %b",
                 i, ALUOp, Funct7, Funct3, is_rtype, Operation, exp);
      end
    end
    drive_idle();
  endtask

  task automatic test_mul();
    for (int i = 0; i < 14; i++) begin
      logic [2:0] f3; logic [31:0] a, b, exp, res; logic sd;
      int lat, ns, nb, el;
      if (i < 4) begin f3 = mf3[i]; a = ma[i]; b = mb[i]; exp = mexp[i]; end
      else begin
        f3 = {1'b0, 2'($urandom)}; a = $urandom; b = $urandom;
        if (i % 3 == 0) b = $urandom_range(0, 9);
        exp = ref_md(f3, a, b);
      end
      el = ref_lat(f3, a, b);
      do_md(f3, a, b, lat, res, ns, nb, sd);
      @(negedge clk); valid_i = 1'b0;
      last_exp = exp;
      n_checks++;
      if (res !== exp) begin n_fail++; $display("FAIL mul_result f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, res, exp); end
      n_checks++;
      if (lat != el) begin n_fail++; $display("FAIL mul_latency f3=%0d: got %0d expected %0d", f3, lat, el); end
      n_checks++;
      if (ns != el || nb != el - 1) begin n_fail++; $display("FAIL mul_stall_busy f3=%0d: got stall=%0d busy=%0d expected %0d/%0d", f3, ns, nb, el, el - 1); end
      n_checks++;
      if (sd !== 1'b0) begin n_fail++; $display("FAIL mul_stall_in_done: got %b expected 0", sd); end
    end
  endtask

  task automatic test_div();
    for (int i = 0; i < 18; i++) begin
      logic [2:0] f3; logic [31:0] a, b, exp, res; logic sd;
      int lat, ns, nb, el;
      if (i < 6) begin f3 = df3[i]; a = da[i]; b = db[i]; exp = dexp[i]; end
      else begin
        f3 = {1'b1, 2'($urandom)}; a = $urandom; b = $urandom;
        case ($urandom_range(0, 5))
          0: b = '0;
          1: b = $urandom_range(1, 20);
          2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
          3: b = 32'hFFFFFFFF - $urandom_range(0, 5);
          default: ;
        endcase
        exp = ref_md(f3, a, b);
      end
      el = ref_lat(f3, a, b);
      do_md(f3, a, b, lat, res, ns, nb, sd);
      @(negedge clk); valid_i = 1'b0;
      last_exp = exp;
      n_checks++;
      if (res !== exp) begin n_fail++; $display("FAIL div_result f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, res, exp); end
      n_checks++;
      if (lat != el) begin n_fail++; $display("FAIL div_latency f3=%0d a=%h b=%h: got %0d expected %0d", f3, a, b, lat, el); end
      n_checks++;
      if (ns != el || nb != el - 1) begin n_fail++; $display("FAIL div_stall_busy f3=%0d: got stall=%0d busy=%0d expected %0d/%0d", f3, ns, nb, el, el - 1); end
      n_checks++;
      if (sd !== 1'b0) begin n_fail++; $display("FAIL div_stall_in_done: got %b expected 0", sd); end
    end
  endtask

  // Aborts a running op with flush_i (use_reset=0) or reset (use_reset=1) at RUN cycle 10.
  task automatic test_abort(input logic use_reset);
    logic [31:0] exp_res;
    int n_valid;
    @(negedge clk);
    valid_i = 1'b1; ALUOp = 2'b10; is_rtype = 1'b1; Funct7 = 7'b0000001;
    Funct3 = use_reset ? 3'd5 : 3'd0; SrcA = 32'd123457; SrcB = 32'd77;
    repeat (10) @(negedge clk);
    if (use_reset) begin reset = 1'b1; valid_i = 1'b0; end
    else flush_i = 1'b1;
    #1;
    if (!use_reset) begin
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", stall); end
    end
    @(negedge clk);
    reset = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    exp_res = use_reset ? 32'd0 : last_exp;
    #1;
    n_checks++;
    if (busy !== 1'b0 || muldiv_valid !== 1'b0 || stall !== 1'b0 || muldiv_result !== exp_res) begin
      n_fail++;
      $display("FAIL abort(reset=%b): got busy=%b valid=%b stall=%b result=%h expected 0/0/0/%h",
               use_reset, busy, muldiv_valid, stall, muldiv_result, exp_res);
    end
    n_valid = 0;
    for (int k = 0; k < W + 5; k++) begin
      @(negedge clk); #1;
      n_valid += int'(muldiv_valid) + int'(busy);
    end
    n_checks++;
    if (n_valid != 0 || muldiv_result !== exp_res) begin
      n_fail++;
      $display("FAIL abort_quiet(reset=%b): got %0d valid/busy cycles result=%h expected 0 and %h",
               use_reset, n_valid, muldiv_result, exp_res);
    end
    last_exp = exp_res;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3], b [3], res;
    logic sd;
    int lat, ns, nb;
    for (int i = 0; i < 3; i++) begin a[i] = $urandom; b[i] = $urandom; end
    for (int i = 0; i < 3; i++) begin
      do_md(3'd0, a[i], b[i], lat, res, ns, nb, sd);
      n_checks++;
      if (res !== ref_md(3'd0, a[i], b[i]) || lat != W + 1 || ns != W + 1) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got result=%h lat=%0d stall=%0d expected %h/%0d/%0d",
                 i, res, lat, ns, ref_md(3'd0, a[i], b[i]), W + 1, W + 1);
      end
    end
    @(negedge clk); valid_i = 1'b0; #1;
    n_checks++;
    if (muldiv_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL back_to_back_tail: got valid=%b busy=%b expected 0/0", muldiv_valid, busy);
    end
  endtask

  task automatic test_non_md();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      valid_i = 1'b1; ALUOp = 2'($urandom); Funct3 = 3'($urandom); is_rtype = 1'($urandom);
      Funct7 = 7'($urandom); SrcA = $urandom; SrcB = $urandom;
      if (ALUOp == 2'b10 && is_rtype && Funct7 == 7'b0000001) Funct7 = 7'b0000000;
      #1;
      n_checks++;
      if (stall !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL non_md[%0d]: got stall=%b busy=%b expected 0/0", i, stall, busy);
      end
    end
    drive_idle();
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_decode();
    test_mul();
    test_div();
    test_abort(1'b0);
    test_back_to_back();
    test_abort(1'b1);
    test_non_md();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
